gaussian_sram_sequencer: RTL and testbench
==========================================

# gaussian_sram_sequencer

Multi-cycle controller that computes one 3x3 Gaussian-filtered pixel from the 8-bit greyscale frame stored in external SRAM. It fetches the nine neighbourhood taps one SRAM read at a time, accumulates the weighted sum with weights 1-2-1 / 2-4-2 / 1-2-1, and returns the rounded, normalised result with a start/valid handshake. It sits between the pixel scheduler (the requester) and the SRAM pins, and owns the SRAM control strobes while active.

## Interface
Parameters:
- IMG_W, 640, frame width in pixels; also the SRAM row stride.
- IMG_H, 480, frame height in pixels.
- ADDR_W, 20, SRAM address width.
- SRAM_WAIT, 1, extra cycles the address is held before data is sampled (0..3).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  request pulse; accepted only when ready=1.
- x, y  in  10 each  centre pixel coordinate; sampled on accept.
- ready  out  1  high only in IDLE.
- valid  out  1  one-cycle pulse: result is valid.
- result  out  8  filtered pixel; holds its value until the next valid.
- SramAddr  out  ADDR_W  word address = row*IMG_W + col.
- CE, OE, WE, LB, UB  out  1 each  SRAM strobes, active-low.
- SramDQ  in  16  SRAM read data; pixel in bits [7:0].

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: ready=1. start=1 latches x, y, clears accumulator, sets tap k=0 and wait count w=0, goes to FETCH. start while not in IDLE is ignored.
- FETCH: tap k=0..8 row-major; tap offset (dx,dy) = (k%3-1, k/3-1); weight = 1,2,1,2,4,2,1,2,1. SramAddr holds the tap address for SRAM_WAIT+1 cycles. At the edge where w==SRAM_WAIT, accumulator += SramDQ[7:0] << log2(weight). If k==8, go to DONE; else k++ and w=0.
- Accumulator: 12 bits unsigned; maximum 255*16=4080, so no overflow.
- DONE: result <= (acc + 8) >> 4, truncated to 8 bits (maximum 255). valid=1 for this one cycle, then return to IDLE.
- Strobes: in FETCH for an enabled tap, CE=OE=LB=UB=0 and WE=1. Otherwise all strobes are 1. WE is never driven 0.
- Boundary taps: handling of taps outside 0..IMG_W-1 / 0..IMG_H-1 is set by the configuration macro below.
- Reset: asynchronous assertion at any time aborts the operation. State returns to IDLE; accumulator, k and w are cleared. No valid pulse is emitted for the aborted request.

## Timing
- Reset values: ready=1, valid=0, result=0, SramAddr=0, CE=OE=WE=LB=UB=1.
- Accept edge is E0. FETCH occupies 9*(SRAM_WAIT+1) cycles. valid is high in the cycle after edge E0 + 9*(SRAM_WAIT+1) (18 cycles for SRAM_WAIT=1).
- ready returns to 1 the cycle after valid. The earliest next accept is one cycle after valid.
- SramDQ is sampled only on the final wait edge of each tap.
- Latency is constant and independent of position or configuration.

## Configuration
- GAUSSIAN_EDGE_CLAMP_EN defined:
  - out-of-range tap coordinates are clamped to the nearest edge (border replication);
  - every tap performs an SRAM read.
- GAUSSIAN_EDGE_CLAMP_EN undefined:
  - an out-of-range tap contributes 0 and still consumes its SRAM_WAIT+1 slot;
  - during that slot CE=OE=LB=UB=1 and SramAddr holds its previous value;
  - the result is still divided by 16.

## Structure
- Shared package gaussian_pkg contains:
  - IMG_W and IMG_H defaults;
  - the state enum typedef (IDLE/FETCH/DONE);
  - the 9-entry weight-shift constant array (0,1,0,1,2,1,0,1,0);
  - the tap-offset function.
- One sub-module, gaussian_tap_addr (combinational). It maps (x, y, k) to {SramAddr, in_range}, and applies clamping when GAUSSIAN_EDGE_CLAMP_EN is defined.

## Test plan
- Uniform frame of value 100, request (320,240), SRAM_WAIT=1 -> valid 18 cycles after accept, result=100, nine reads observed.
- Impulse: 255 at (10,10), 0 elsewhere, request (10,10) -> result=(1020+8)>>4=64. Request (11,10) -> (510+8)>>4=32.
- Address order: request (5,3) -> first SramAddr=2*640+4=1284, last=4*640+6=2566, each held 2 cycles.
- Corner (0,0) on a uniform 200 frame:
  - with GAUSSIAN_EDGE_CLAMP_EN -> result=200;
  - without -> (1800+8)>>4=113, and CE=1 during the 5 out-of-range slots.
- start pulsed in FETCH cycle 4 -> ignored; exactly one valid is produced, and ready stays 0 until after it.
- Reset_n low in FETCH cycle 7 -> strobes immediately 1, ready=1, no valid. A new request completes with the correct value.

Source files
------------

// File: rtl/gaussian_pkg.sv
// rtl/gaussian_pkg.sv - shared types, weights and tap geometry for the 3x3 Gaussian sequencer
package gaussian_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    // Weights 1-2-1 / 2-4-2 / 1-2-1 stored as left-shift amounts.
    localparam logic [8:0][1:0] W_SHIFT = {2'd0, 2'd1, 2'd0,
                                           2'd1, 2'd2, 2'd1,
                                           2'd0, 2'd1, 2'd0};

    // Offsets are two's complement in the range -1..1.
    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } tap_off_t;

    function automatic tap_off_t tap_offset(input logic [3:0] k);
        tap_off_t o;
        o.dx = 2'b00;
        o.dy = 2'b00;
        if (k == 4'd0 || k == 4'd3 || k == 4'd6)
            o.dx = 2'b11;
        else if (k == 4'd2 || k == 4'd5 || k == 4'd8)
            o.dx = 2'b01;
        if (k < 4'd3)
            o.dy = 2'b11;
        else if (k >= 4'd6)
            o.dy = 2'b01;
        return o;
    endfunction

endpackage

// File: rtl/gaussian_tap_addr.sv
// rtl/gaussian_tap_addr.sv - maps (x, y, k) to an SRAM word address; GAUSSIAN_EDGE_CLAMP_EN selects border replication
module gaussian_tap_addr #(
    parameter int IMG_W  = gaussian_pkg::IMG_W_DEF,
    parameter int IMG_H  = gaussian_pkg::IMG_H_DEF,
    parameter int ADDR_W = 20
) (
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [3:0]        k,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);
    import gaussian_pkg::*;

    localparam logic [11:0]       W12    = 12'(IMG_W);
    localparam logic [11:0]       H12    = 12'(IMG_H);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);

    tap_off_t    off;
    logic [11:0] col;
    logic [11:0] row;
    logic [11:0] col_a;
    logic [11:0] row_a;
    logic        col_lo;
    logic        col_hi;
    logic        row_lo;
    logic        row_hi;

    assign off = tap_offset(k);
    // Bit 11 set means the tap fell off the low edge (wrapped negative).
    assign col = {2'b00, x} + {{10{off.dx[1]}}, off.dx};
    assign row = {2'b00, y} + {{10{off.dy[1]}}, off.dy};

    assign col_lo = col[11];
    assign row_lo = row[11];
    assign col_hi = !col[11] && (col >= W12);
    assign row_hi = !row[11] && (row >= H12);

`ifdef GAUSSIAN_EDGE_CLAMP_EN
    assign col_a    = col_lo ? 12'd0 : (col_hi ? W12 - 12'd1 : col);
    assign row_a    = row_lo ? 12'd0 : (row_hi ? H12 - 12'd1 : row);
    assign in_range = 1'b1;
`else
    assign col_a    = col;
    assign row_a    = row;
    assign in_range = !(col_lo || col_hi || row_lo || row_hi);
`endif

    assign addr = ADDR_W'(row_a) * STRIDE + ADDR_W'(col_a);

endmodule

// File: rtl/gaussian_sram_sequencer.sv
// rtl/gaussian_sram_sequencer.sv - 3x3 Gaussian pixel from SRAM, one read per tap; edge mode via GAUSSIAN_EDGE_CLAMP_EN
module gaussian_sram_sequencer #(
    parameter int IMG_W     = gaussian_pkg::IMG_W_DEF,
    parameter int IMG_H     = gaussian_pkg::IMG_H_DEF,
    parameter int ADDR_W    = 20,
    parameter int SRAM_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic              ready,
    output logic              valid,
    output logic [7:0]        result,
    output logic [ADDR_W-1:0] SramAddr,
    output logic              CE,
    output logic              OE,
    output logic              WE,
    output logic              LB,
    output logic              UB,
    input  logic [15:0]       SramDQ
);
    import gaussian_pkg::*;

    localparam logic [1:0] WAIT2 = 2'(SRAM_WAIT);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        k;
    logic [1:0]        w;
    logic [11:0]       acc;
    logic [11:0]       contrib;
    logic [11:0]       acc_sum;
    logic [11:0]       acc_rnd;
    logic [9:0]        xr;
    logic [9:0]        yr;
    logic [ADDR_W-1:0] tap_addr;
    logic [ADDR_W-1:0] addr_hold;
    logic              in_range;
    logic              last_wait;
    logic              en;
    logic              dq_unused;

    gaussian_tap_addr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_tap_addr (
        .x       (xr),
        .y       (yr),
        .k       (k),
        .addr    (tap_addr),
        .in_range(in_range)
    );

    assign dq_unused = ^SramDQ[15:8];
    assign last_wait = (w == WAIT2);
    assign contrib   = in_range ? ({4'b0000, SramDQ[7:0]} << W_SHIFT[k]) : 12'd0;
    assign acc_sum   = acc + contrib;
    assign acc_rnd   = acc_sum + 12'd8;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        valid    = 1'b0;
        en       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start)
                    state_nx = FETCH;
            end
            FETCH: begin
                en = in_range;
                if (last_wait && k == 4'd8)
                    state_nx = DONE;
            end
            DONE: begin
                valid    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are pure decode of state so an async reset releases the bus at once.
    assign CE       = ~en;
    assign OE       = ~en;
    assign LB       = ~en;
    assign UB       = ~en;
    assign WE       = 1'b1;
    assign SramAddr = en ? tap_addr : addr_hold;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            k         <= 4'd0;
            w         <= 2'd0;
            acc       <= 12'd0;
            xr        <= 10'd0;
            yr        <= 10'd0;
            result    <= 8'd0;
            addr_hold <= '0;
        end else begin
            if (en)
                addr_hold <= tap_addr;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr  <= x;
                        yr  <= y;
                        acc <= 12'd0;
                        k   <= 4'd0;
                        w   <= 2'd0;
                    end
                end
                FETCH: begin
                    if (last_wait) begin
                        acc <= acc_sum;
                        w   <= 2'd0;
                        // Result registers on the last sample so it is stable while valid is high.
                        if (k == 4'd8)
                            result <= acc_rnd[11:4];
                        else
                            k <= k + 4'd1;
                    end else begin
                        w <= w + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gaussian_sram_sequencer.sv
// tb/tb_gaussian_sram_sequencer.sv - directed self-checking bench for gaussian_sram_sequencer
module tb_gaussian_sram_sequencer;

    logic        Clk     = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [9:0]  x       = 10'd0;
    logic [9:0]  y       = 10'd0;
    logic        ready;
    logic        valid;
    logic [7:0]  result;
    logic [19:0] SramAddr;
    logic        CE, OE, WE, LB, UB;
    logic [15:0] SramDQ;

    int          checks   = 0;
    int          failures = 0;
    int          mode     = 0;
    logic [7:0]  uval     = 8'd0;
    logic [19:0] imp_addr = 20'd0;

    int          lat, ce_cnt, ready_hi, we_bad, nvalid;
    logic [7:0]  res;
    logic        valid_after, ready_after;
    logic [19:0] addrs[$];

    gaussian_sram_sequencer dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .x       (x),
        .y       (y),
        .ready   (ready),
        .valid   (valid),
        .result  (result),
        .SramAddr(SramAddr),
        .CE      (CE),
        .OE      (OE),
        .WE      (WE),
        .LB      (LB),
        .UB      (UB),
        .SramDQ  (SramDQ)
    );

    always #5 Clk = ~Clk;

    // Frame model: uniform value or a single 255 impulse; junk in the high byte.
    always_comb begin
        SramDQ = 16'hA500;
        if (mode == 0)
            SramDQ[7:0] = uval;
        else
            SramDQ[7:0] = (SramAddr == imp_addr) ? 8'd255 : 8'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [9:0] cx, input logic [9:0] cy, input int pulse_at);
        addrs.delete();
        ce_cnt   = 0;
        ready_hi = 0;
        we_bad   = 0;
        lat      = 0;
        @(negedge Clk);
        x     = cx;
        y     = cy;
        start = 1'b1;
        @(posedge Clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            start = (lat == pulse_at);
            if (valid) break;
            if (!CE) begin
                ce_cnt++;
                addrs.push_back(SramAddr);
            end
            if (ready) ready_hi++;
            if (WE !== 1'b1) we_bad++;
            @(posedge Clk);
            lat++;
        end
        start = 1'b0;
        res   = result;
        @(posedge Clk);
        @(negedge Clk);
        valid_after = valid;
        ready_after = ready;
    endtask

    task automatic count_valids(input int cycles);
        nvalid = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (valid) nvalid++;
        end
    endtask

    initial begin
        #12;
        check("rst_ready",   32'(ready), 32'd1);
        check("rst_valid",   32'(valid), 32'd0);
        check("rst_result",  32'(result), 32'd0);
        check("rst_addr",    32'(SramAddr), 32'd0);
        check("rst_strobes", 32'({CE, OE, WE, LB, UB}), 32'h1F);
        @(negedge Clk);
        Reset_n = 1'b1;

        mode = 0;
        uval = 8'd100;
        run_req(10'd320, 10'd240, -1);
        check("uni_latency",  32'(lat), 32'd18);
        check("uni_result",   32'(res), 32'd100);
        check("uni_ce_cycles", 32'(ce_cnt), 32'd18);
        check("uni_we_high",  32'(we_bad), 32'd0);
        check("uni_valid_1cy", 32'(valid_after), 32'd0);
        check("uni_ready_back", 32'(ready_after), 32'd1);

        mode     = 1;
        imp_addr = 20'd6410;
        run_req(10'd10, 10'd10, -1);
        check("imp_centre", 32'(res), 32'd64);
        run_req(10'd11, 10'd10, -1);
        check("imp_side", 32'(res), 32'd32);

        mode = 0;
        uval = 8'd7;
        run_req(10'd5, 10'd3, -1);
        check("ord_count", 32'(addrs.size()), 32'd18);
        if (addrs.size() == 18) begin
            check("ord_first",  32'(addrs[0]), 32'd1284);
            check("ord_hold",   32'(addrs[1]), 32'd1284);
            check("ord_second", 32'(addrs[2]), 32'd1285);
            check("ord_last",   32'(addrs[17]), 32'd2566);
        end
        check("ord_result", 32'(res), 32'd7);

        uval = 8'd200;
        run_req(10'd0, 10'd0, -1);
        check("corner_latency", 32'(lat), 32'd18);
`ifdef GAUSSIAN_EDGE_CLAMP_EN
        check("corner_result", 32'(res), 32'd200);
        check("corner_ce",     32'(ce_cnt), 32'd18);
`else
        check("corner_result", 32'(res), 32'd113);
        check("corner_ce",     32'(ce_cnt), 32'd8);
`endif

        uval = 8'd50;
        run_req(10'd100, 10'd100, 4);
        check("busy_latency", 32'(lat), 32'd18);
        check("busy_result",  32'(res), 32'd50);
        check("busy_ready_low", 32'(ready_hi), 32'd0);
        count_valids(30);
        check("busy_no_extra_valid", 32'(nvalid), 32'd0);

        mode     = 1;
        imp_addr = 20'd6410;
        @(negedge Clk);
        x     = 10'd10;
        y     = 10'd10;
        start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        repeat (6) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("abort_strobes", 32'({CE, OE, WE, LB, UB}), 32'h1F);
        check("abort_ready",   32'(ready), 32'd1);
        check("abort_valid",   32'(valid), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        count_valids(30);
        check("abort_no_valid", 32'(nvalid), 32'd0);
        run_req(10'd10, 10'd10, -1);
        check("abort_redo_latency", 32'(lat), 32'd18);
        check("abort_redo_result",  32'(res), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
